// File: rtl/uart_rx_deser.sv
// uart_rx_deser: oversampling UART receiver with 3-sample majority vote, optional parity and stop check.
// Define UART_RX_ERR_CNT_EN to add the saturating err_cnt output.
module uart_rx_deser #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
`ifdef UART_RX_ERR_CNT_EN
    output logic                  stp_err,
    output logic [7:0]            err_cnt
`else
    output logic                  stp_err
`endif
);
    localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [PRESCALE_W-1:0] ONE = 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                  state;
    logic                    rx_m, rx_s, s0, s1, bit_v, par_flag, stp_flag;
    logic [PRESCALE_W-1:0]   edge_cnt;
    logic [BW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    last, at_lo, at_mid, at_hi, vote, ok;

    always_comb begin
        last   = edge_cnt == prescale - ONE;
        at_lo  = edge_cnt == (prescale >> 1) - ONE;
        at_mid = edge_cnt == (prescale >> 1);
        at_hi  = edge_cnt == (prescale >> 1) + ONE;
        vote   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
        ok     = !par_flag && !stp_flag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            s0         <= 1'b0;
            s1         <= 1'b0;
            bit_v      <= 1'b0;
            par_flag   <= 1'b0;
            stp_flag   <= 1'b0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
`ifdef UART_RX_ERR_CNT_EN
            err_cnt    <= '0;
`endif
        end else begin
            rx_m       <= RX_IN;
            rx_s       <= rx_m;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (state != IDLE) edge_cnt <= last ? '0 : edge_cnt + ONE;
            if (at_lo) s0 <= rx_s;
            if (at_mid) s1 <= rx_s;
            if (at_hi) bit_v <= vote;
            case (state)
                IDLE: if (!rx_s) begin
                    state    <= START;
                    edge_cnt <= ONE;
                    par_flag <= 1'b0;
                    stp_flag <= 1'b0;
                end
                START: if (last) begin
                    state   <= bit_v ? IDLE : DATA;
                    bit_cnt <= '0;
                end
                DATA: begin
                    if (at_hi) shreg[bit_cnt] <= vote;
                    if (last && bit_cnt == BIT_LAST) state <= PAR_EN ? PARITY : STOP;
                    if (last && bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + BW'(1);
                end
                PARITY: begin
                    if (at_hi) par_flag <= (^shreg ^ PAR_TYP) != vote;
                    if (last) state <= STOP;
                end
                STOP: begin
                    if (at_hi) stp_flag <= !vote;
                    if (last) begin
                        state      <= IDLE;
                        data_valid <= ok;
                        par_err    <= par_flag;
                        stp_err    <= stp_flag;
                        if (ok) P_DATA <= shreg;
`ifdef UART_RX_ERR_CNT_EN
                        if (!ok && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_deser.sv
// tb_uart_rx_deser: table-driven frame vectors plus glitch, back-to-back and mid-frame reset sequences.
module tb_uart_rx_deser;
    logic       clk = 1'b0, rst = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid, par_err, stp_err;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
    int         exp_ec = 0;
`endif

    uart_rx_deser dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
        .data_valid(data_valid), .par_err(par_err),
`ifdef UART_RX_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .stp_err(stp_err)
    );

    always #5 clk = ~clk;

    int nv = 0, np = 0, ns = 0;
    logic [7:0] last_d = 8'h00, prev_d = 8'h00;
    always @(negedge clk) if (!rst) begin
        if (data_valid) begin
            prev_d = last_d;
            last_d = P_DATA;
            nv++;
        end
        if (par_err) np++;
        if (stp_err) ns++;
    end

    int pass = 0, total = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            RX_IN = v;
            @(negedge clk);
        end
    endtask

    task automatic frame(input logic [7:0] d, input int p, input bit pe, input bit pb, input bit sb);
        drive(1'b0, p);
        for (int i = 0; i < 8; i++) drive(d[i], p);
        if (pe) drive(pb, p);
        drive(sb, p);
    endtask

    typedef struct {
        int p; bit pe; bit pt; logic [7:0] d; bit pb; bit sb;
        int ev; int epe; int ese; logic [7:0] epd;
    } vec_t;
    vec_t vt[6];

    initial begin
        int v0, p0, s0;
        vt[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1, 0, 0, 8'hA5};
        vt[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 0, 1, 0, 8'hA5};
        vt[2] = '{8,  1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 0, 0, 1, 8'hA5};
        vt[3] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1, 0, 0, 8'h3C};
        vt[4] = '{32, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1, 0, 0, 8'h07};
        vt[5] = '{8,  1'b1, 1'b1, 8'h07, 1'b1, 1'b0, 0, 1, 1, 8'h07};
        repeat (3) @(negedge clk);
        chk("reset P_DATA", P_DATA, 0);
        chk("reset data_valid", data_valid, 0);
        chk("reset par_err", par_err, 0);
        chk("reset stp_err", stp_err, 0);
        rst = 1'b0;
        drive(1'b1, 4);

        for (int k = 0; k < 6; k++) begin
            prescale = 6'(vt[k].p);
            PAR_EN = vt[k].pe;
            PAR_TYP = vt[k].pt;
            v0 = nv; p0 = np; s0 = ns;
            frame(vt[k].d, vt[k].p, vt[k].pe, vt[k].pb, vt[k].sb);
            drive(1'b1, 8);
            chk($sformatf("vec%0d valid", k), nv - v0, vt[k].ev);
            chk($sformatf("vec%0d par_err", k), np - p0, vt[k].epe);
            chk($sformatf("vec%0d stp_err", k), ns - s0, vt[k].ese);
            chk($sformatf("vec%0d P_DATA", k), P_DATA, vt[k].epd);
`ifdef UART_RX_ERR_CNT_EN
            if (vt[k].epe != 0 || vt[k].ese != 0) exp_ec++;
            chk($sformatf("vec%0d err_cnt", k), err_cnt, exp_ec);
`endif
        end

        prescale = 6'd16; PAR_EN = 1'b0;
        v0 = nv; p0 = np; s0 = ns;
        drive(1'b0, 3);
        drive(1'b1, 30);
        chk("glitch valid", nv - v0, 0);
        chk("glitch par_err", np - p0, 0);
        chk("glitch stp_err", ns - s0, 0);
        frame(8'h81, 16, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8);
        chk("post-glitch valid", nv - v0, 1);
        chk("post-glitch P_DATA", P_DATA, 8'h81);

        prescale = 6'd32; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        v0 = nv;
        frame(8'h00, 32, 1'b1, 1'b1, 1'b1);
        frame(8'hFF, 32, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 8);
        chk("b2b valid count", nv - v0, 2);
        chk("b2b first byte", prev_d, 8'h00);
        chk("b2b second byte", last_d, 8'hFF);

        prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        drive(1'b0, 8);
        for (int i = 0; i < 4; i++) drive(8'h96 >> i, 8);
        drive(1'b1, 4);
        rst = 1'b1;
        #1;
        chk("midrst P_DATA", P_DATA, 0);
        chk("midrst data_valid", data_valid, 0);
        chk("midrst par_err", par_err, 0);
        chk("midrst stp_err", stp_err, 0);
`ifdef UART_RX_ERR_CNT_EN
        chk("midrst err_cnt", err_cnt, 0);
`endif
        RX_IN = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        v0 = nv;
        drive(1'b1, 4);
        frame(8'h96, 8, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 8);
        chk("post-reset valid", nv - v0, 1);
        chk("post-reset P_DATA", P_DATA, 8'h96);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
